// File: rtl/stf_pkg.sv
// Shared types and helpers for the slow-to-fast event path (stf_sync consumers).
package stf_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   function automatic int unsigned id_width(input int unsigned n);
      return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
   endfunction

endpackage

// File: rtl/stf_event_dispatch_if.sv
// Valid/ready event offer channel from the dispatcher to its fast-domain client.
interface stf_event_dispatch_if #(
   parameter int unsigned ID_W = 1
);

   logic            req_valid;
   logic [ID_W-1:0] req_id;
   logic            req_ready;

   modport master (output req_valid, output req_id, input req_ready);
   modport slave  (input req_valid, input req_id, output req_ready);

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first set request at or above rr_ptr, with wrap.
module rr_arbiter
   import stf_pkg::*;
#(
   parameter int unsigned N    = 2,
   parameter int unsigned ID_W = 1
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] rr_ptr,
   output logic            grant_valid,
   output logic [ID_W-1:0] grant_id
);

   int unsigned idx;

   // Offsets are scanned from farthest to nearest so the nearest hit is assigned last.
   always_comb begin
      grant_valid = 1'b0;
      grant_id    = '0;
      idx         = 0;
      for (int unsigned k = N; k > 0; k--) begin
         idx = (32'(rr_ptr) + k - 32'd1) % N;
         if (req[idx]) begin
            grant_valid = 1'b1;
            grant_id    = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/stf_event_dispatch.sv
// Rising-edge capture of synchronized event lines, overrun tracking and
// round-robin dispatch of one event at a time over a valid/ready channel.
module stf_event_dispatch
   import stf_pkg::*;
#(
   parameter  int unsigned N     = 2,
   parameter  int unsigned CNT_W = 8,
   localparam int unsigned ID_W  = id_width(N)
) (
   input  logic                 fastclk,
   input  logic                 rst,
   input  logic [N-1:0]         synced,
   stf_event_dispatch_if.master req,
   output logic [N-1:0]         pending,
   output logic [N-1:0]         overrun,
   output logic [CNT_W-1:0]     overrun_cnt,
   input  logic                 clr_overrun
);

   state_t          state, state_nx;
   logic [N-1:0]    prev;
   logic            armed;
   logic [ID_W-1:0] rr_ptr, ptr_nx, id_nx;
   logic            valid_nx;
   logic            handshake;
   logic [N-1:0]    rise, clr_vec, ovr_hit, pending_nx, overrun_nx;
   logic [CNT_W-1:0] cnt_nx;
   logic            grant_valid;
   logic [ID_W-1:0] grant_id;

   rr_arbiter #(.N(N), .ID_W(ID_W)) u_arb (
      .req         (pending),
      .rr_ptr      (rr_ptr),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   // A new edge on a bit being handed off this cycle re-sets it without counting as overrun.
   always_comb begin
      handshake = req.req_valid & req.req_ready;
      rise      = armed ? (synced & ~prev) : '0;
      clr_vec   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         clr_vec[i] = handshake && (req.req_id == ID_W'(i));
      end
      ovr_hit    = rise & pending & ~clr_vec;
      pending_nx = (pending & ~clr_vec) | rise;
      overrun_nx = (clr_overrun ? '0 : overrun) | ovr_hit;
      cnt_nx     = clr_overrun ? '0 : overrun_cnt;
      for (int unsigned i = 0; i < N; i++) begin
         if (ovr_hit[i] && (cnt_nx != '1)) begin
            cnt_nx = cnt_nx + CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_nx = state;
      valid_nx = req.req_valid;
      id_nx    = req.req_id;
      ptr_nx   = rr_ptr;
      case (state)
         IDLE: begin
            if (grant_valid) begin
               valid_nx = 1'b1;
               id_nx    = grant_id;
               state_nx = REQ;
            end
         end
         REQ: begin
            if (req.req_ready) begin
               valid_nx = 1'b0;
               ptr_nx   = (32'(req.req_id) + 32'd1 >= N) ? '0 : req.req_id + ID_W'(1);
               state_nx = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge fastclk) begin
      if (rst) begin
         state         <= IDLE;
         prev          <= '0;
         armed         <= 1'b0;
         rr_ptr        <= '0;
         pending       <= '0;
         overrun       <= '0;
         overrun_cnt   <= '0;
         req.req_valid <= 1'b0;
         req.req_id    <= '0;
      end else begin
         state         <= state_nx;
         prev          <= synced;
         armed         <= 1'b1;
         rr_ptr        <= ptr_nx;
         pending       <= pending_nx;
         overrun       <= overrun_nx;
         overrun_cnt   <= cnt_nx;
         req.req_valid <= valid_nx;
         req.req_id    <= id_nx;
      end
   end

endmodule

// File: tb/tb_stf_event_dispatch.sv
// Bench for stf_event_dispatch: directed scenarios plus random traffic against
// an event-level reference model; a second N=1 instance covers the single-line build.
module tb_stf_event_dispatch;

   localparam int unsigned N       = 2;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned ID_W    = 1;
   localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

   logic fastclk = 1'b0;
   always #5 fastclk = ~fastclk;

   logic             rst, clr_overrun;
   logic [N-1:0]     synced, pending, overrun;
   logic [CNT_W-1:0] overrun_cnt;
   stf_event_dispatch_if #(.ID_W(ID_W)) bus ();

   stf_event_dispatch #(.N(N), .CNT_W(CNT_W)) dut (
      .fastclk     (fastclk),
      .rst         (rst),
      .synced      (synced),
      .req         (bus),
      .pending     (pending),
      .overrun     (overrun),
      .overrun_cnt (overrun_cnt),
      .clr_overrun (clr_overrun)
   );

   logic             rst1, clr1;
   logic [0:0]       synced1, pending1, overrun1;
   logic [CNT_W-1:0] cnt1;
   stf_event_dispatch_if #(.ID_W(1)) bus1 ();

   stf_event_dispatch #(.N(1), .CNT_W(CNT_W)) dut1 (
      .fastclk     (fastclk),
      .rst         (rst1),
      .synced      (synced1),
      .req         (bus1),
      .pending     (pending1),
      .overrun     (overrun1),
      .overrun_cnt (cnt1),
      .clr_overrun (clr1)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: pending events as a set of bits, one outstanding offer at a time.
   bit [N-1:0] m_prev, m_pend, m_ovr;
   bit         m_armed, m_busy;
   int         m_id, m_ptr, m_cnt;

   task automatic model_step();
      bit [N-1:0] old_pend;
      bit hs, r, clearing;
      int c;
      if (rst) begin
         m_prev = '0; m_pend = '0; m_ovr = '0;
         m_armed = 0; m_busy = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
         return;
      end
      old_pend = m_pend;
      hs = m_busy && bus.req_ready;
      c  = clr_overrun ? 0 : m_cnt;
      if (clr_overrun) m_ovr = '0;
      for (int i = 0; i < int'(N); i++) begin
         r        = m_armed && synced[i] && !m_prev[i];
         clearing = hs && (m_id == i);
         if (r && old_pend[i] && !clearing) begin
            m_ovr[i] = 1'b1;
            if (c < int'(CNT_MAX)) c++;
         end
         if (r) m_pend[i] = 1'b1;
         else if (clearing) m_pend[i] = 1'b0;
      end
      m_cnt   = c;
      m_prev  = synced;
      m_armed = 1;
      if (!m_busy) begin
         for (int k = 0; k < int'(N); k++) begin
            if (old_pend[(m_ptr + k) % int'(N)]) begin
               m_busy = 1;
               m_id   = (m_ptr + k) % int'(N);
               break;
            end
         end
      end else if (hs) begin
         m_busy = 0;
         m_ptr  = (m_id + 1) % int'(N);
      end
   endtask

   task automatic tick();
      @(posedge fastclk);
      model_step();
      @(negedge fastclk);
      check("req_valid", 32'(bus.req_valid), 32'(m_busy));
      check("req_id", 32'(bus.req_id), m_id);
      check("pending", 32'(pending), 32'(m_pend));
      check("overrun", 32'(overrun), 32'(m_ovr));
      check("overrun_cnt", 32'(overrun_cnt), m_cnt);
   endtask

   initial begin
      bit saw_valid;
      int n;
      rst = 1; synced = 2'b11; bus.req_ready = 1; clr_overrun = 0;
      rst1 = 1; synced1 = 1'b0; bus1.req_ready = 0; clr1 = 0;
      repeat (3) tick();

      // Lines high out of reset never produce an event
      rst = 0; saw_valid = 0;
      repeat (10) begin
         tick();
         if (bus.req_valid) saw_valid = 1;
      end
      check("c1_no_req", 32'(saw_valid), 0);
      check("c1_pending", 32'(pending), 0);

      synced = 2'b00; bus.req_ready = 0;
      repeat (3) tick();
      synced = 2'b01; tick();
      check("c2_pend_k", 32'(pending), 1);
      check("c2_valid_k", 32'(bus.req_valid), 0);
      tick();
      check("c2_valid_k1", 32'(bus.req_valid), 1);
      check("c2_id_k1", 32'(bus.req_id), 0);
      repeat (3) tick();
      check("c2_hold", 32'(bus.req_valid), 1);
      bus.req_ready = 1; tick();
      check("c2_pend_clr", 32'(pending), 0);
      check("c2_valid_clr", 32'(bus.req_valid), 0);

      rst = 1; synced = 2'b00; tick();
      rst = 0; repeat (2) tick();
      synced = 2'b11; tick();
      check("c3_pend", 32'(pending), 3);
      tick();
      check("c3_g0_valid", 32'(bus.req_valid), 1);
      check("c3_g0_id", 32'(bus.req_id), 0);
      tick();
      check("c3_bubble", 32'(bus.req_valid), 0);
      tick();
      check("c3_g1_valid", 32'(bus.req_valid), 1);
      check("c3_g1_id", 32'(bus.req_id), 1);
      tick();
      check("c3_done", 32'(pending), 0);

      bus.req_ready = 0; synced = 2'b00; tick();
      synced = 2'b01; tick();
      synced = 2'b00; tick();
      synced = 2'b01; tick();
      check("c4_ovr1", 32'(overrun), 1);
      check("c4_cnt1", 32'(overrun_cnt), 1);
      repeat (299) begin
         synced = 2'b00; tick();
         synced = 2'b01; tick();
      end
      check("c4_sat", 32'(overrun_cnt), CNT_MAX);
      clr_overrun = 1; tick();
      clr_overrun = 0;
      check("c4_clr_ovr", 32'(overrun), 0);
      check("c4_clr_cnt", 32'(overrun_cnt), 0);
      bus.req_ready = 1; synced = 2'b00;
      repeat (6) tick();

      bus.req_ready = 0; synced = 2'b10; tick();
      n = 0;
      while (!(bus.req_valid && bus.req_id == 1'b1) && n < 10) begin
         tick();
         n++;
      end
      check("c5_offer", 32'(bus.req_valid && bus.req_id == 1'b1), 1);
      synced = 2'b00; tick();
      synced = 2'b10; bus.req_ready = 1; tick();
      bus.req_ready = 0;
      check("c5_pend", 32'(pending), 2);
      check("c5_ovr", 32'(overrun), 0);
      check("c5_bubble", 32'(bus.req_valid), 0);
      tick();
      check("c5_reoffer", 32'(bus.req_valid), 1);
      check("c5_reoffer_id", 32'(bus.req_id), 1);
      bus.req_ready = 1; synced = 2'b00; tick();

      repeat (2000) begin
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 3) == 0) synced = N'($urandom);
         bus.req_ready = ($urandom_range(0, 2) != 0);
         clr_overrun = ($urandom_range(0, 49) == 0);
         tick();
      end
      rst = 0; clr_overrun = 0;

      rst1 = 0; tick();
      synced1 = 1'b0; tick();
      synced1 = 1'b1; tick();
      check("c6_pend_k", 32'(pending1), 1);
      check("c6_valid_k", 32'(bus1.req_valid), 0);
      tick();
      check("c6_valid_k1", 32'(bus1.req_valid), 1);
      check("c6_id", 32'(bus1.req_id), 0);
      rst1 = 1; tick();
      check("c6_rst_valid", 32'(bus1.req_valid), 0);
      check("c6_rst_pend", 32'(pending1), 0);
      rst1 = 0; repeat (3) tick();
      check("c6_rearm_quiet", 32'(pending1), 0);
      synced1 = 1'b0; tick();
      synced1 = 1'b1; repeat (2) tick();
      check("c6_second_valid", 32'(bus1.req_valid), 1);
      bus1.req_ready = 1; tick();
      check("c6_drain_valid", 32'(bus1.req_valid), 0);
      check("c6_drain_pend", 32'(pending1), 0);
      check("c6_no_ovr", 32'(overrun1), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
